// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the wait-stated data-memory responder.
package data_memory_responder_pkg;

  localparam int unsigned WAIT_CNT_W = 4;
  localparam int unsigned WORD_LSB   = 2;
  localparam int unsigned BUS_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Kind and error conditions of an accepted request, fixed at acceptance.
  typedef struct packed {
    logic is_write;
    logic misaligned;
    logic conflict;
  } req_kind_t;

  function automatic req_kind_t classify_req(input logic rd, input logic wr,
                                             input logic [1:0] byte_off);
    req_kind_t k;
    k.is_write   = wr;
    k.misaligned = |byte_off;
    k.conflict   = rd & wr;
    return k;
  endfunction

endpackage

// File: rtl/dm_word_ram.sv
// Single-port word array: synchronous write, registered read that reads as zero when idle.
module dm_word_ram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read port register, zero on any cycle without a read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Wait-stated data-memory responder: accepts one load/store, stalls, then pulses Ready.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  MemoryRead,
  input  logic                  MemoryWrite,
  input  logic [BUS_ADDR_W-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Ready,
  output logic                  Stall,
  output logic                  Misaligned,
  output logic                  Conflict
);

  state_t                state;
  state_t                state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt_next;

  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  req_kind_t             kind_q;

  logic                  req;
  req_kind_t             live_kind;
  logic [ADDR_WIDTH-1:0] live_idx;

  logic                  accept;
  logic                  done_enter;
  req_kind_t             cur_kind;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [DATA_WIDTH-1:0] cur_wdata;

  logic                  ram_we;
  logic                  ram_re;
  logic                  access_ok;

  logic                  unused_addr_hi;

  assign req       = MemoryRead | MemoryWrite;
  assign live_kind = classify_req(MemoryRead, MemoryWrite, Address[1:0]);
  assign live_idx  = Address[WORD_LSB +: ADDR_WIDTH];

  // Bits above the word index only wrap the address and are intentionally dropped.
  assign unused_addr_hi = ^Address[BUS_ADDR_W-1:ADDR_WIDTH+WORD_LSB];

  // State register.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, stall, and selection of the request that is about to complete.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    Stall         = 1'b0;
    accept        = 1'b0;
    done_enter    = 1'b0;
    cur_kind      = kind_q;
    cur_idx       = idx_q;
    cur_wdata     = wdata_q;

    case (state)
      ST_IDLE: begin
        // With no wait states the access completes straight from the live inputs.
        cur_kind  = live_kind;
        cur_idx   = live_idx;
        cur_wdata = WriteData;
        if (req) begin
          Stall         = 1'b1;
          accept        = 1'b1;
          wait_cnt_next = WAIT_CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_next = ST_DONE;
            done_enter = 1'b1;
          end else begin
            state_next = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        Stall         = 1'b1;
        wait_cnt_next = wait_cnt - WAIT_CNT_W'(1);
        if (wait_cnt == WAIT_CNT_W'(1)) begin
          state_next = ST_DONE;
          done_enter = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Array is touched only on the completing edge, never under reset or an error.
  assign access_ok = Reset & done_enter & ~cur_kind.misaligned & ~cur_kind.conflict;
  assign ram_we    = access_ok &  cur_kind.is_write;
  assign ram_re    = access_ok & ~cur_kind.is_write;

  // Wait counter, request latch and completion flags.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wait_cnt   <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      kind_q     <= '0;
      Ready      <= 1'b0;
      Misaligned <= 1'b0;
      Conflict   <= 1'b0;
    end else begin
      wait_cnt   <= wait_cnt_next;
      Ready      <= done_enter;
      Misaligned <= done_enter & cur_kind.misaligned;
      Conflict   <= done_enter & cur_kind.conflict;
      if (accept) begin
        idx_q   <= live_idx;
        wdata_q <= WriteData;
        kind_q  <= live_kind;
      end
    end
  end

  dm_word_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (Clock),
    .rst_n(Reset),
    .we   (ram_we),
    .re   (ram_re),
    .addr (cur_idx),
    .wdata(cur_wdata),
    .rdata(ReadData)
  );

endmodule
